time_set_editor: RTL and testbench
==================================

# time_set_editor

Parametrised successor to the current set-time path: a debounced, auto-repeating field editor for year/month/day/hour/min/sec with calendar-correct limits. Five raw push-buttons drive selection, increment/decrement and commit. Edited values feed the display and clock-counter load path. Unlike the current block, it debounces internally, repeats while a button is held, clamps the day to the month length (including leap years), and emits a one-cycle commit strobe.

## Interface
Parameters:
- DEBOUNCE_CYC, 20000: cycles a raw button must be stable before its level is accepted.
- REPEAT_DELAY_CYC, 500000: hold time before auto-repeat starts.
- REPEAT_RATE_CYC, 100000: period between auto-repeat steps.
- BLINK_CYC, 250000: half-period of the `blink` output.
- YEAR_MIN, 2001: lowest editable year.
- YEAR_MAX, 2099: highest editable year (≤ 32767).

Ports (one clock; reset is synchronous and active-high):
- clk, in, 1: system clock.
- rst, in, 1: synchronous active-high reset.
- button_mid / button_l / button_r / button_up / button_down, in, 1 each: raw, asynchronous, active-high.
- cur_year / cur_month / cur_day / cur_hour / cur_min / cur_sec, in, 15/4/5/6/6/6: running time, loaded on edit entry.
- year_d / month_d / day_d / hour_d / min_d / sec_d, out, 15/4/5/6/6/6: edited values.
- field, out, 3: selected field, 0=year … 5=sec.
- editing, out, 1: high while in EDIT.
- blink, out, 1: toggles every BLINK_CYC cycles while editing, otherwise 0.
- commit, out, 1: one-cycle pulse when edits are committed.

## Operation
- Each button passes through a 2-FF synchroniser and a stability counter. A press event is the 0→1 transition of the debounced level.
- FSM states: IDLE and EDIT.
- IDLE, mid press: load all outputs from the cur_* inputs, set field=0, then go to EDIT. All other buttons are ignored in IDLE.
- EDIT, mid press: pulse commit for one cycle and go to IDLE. Outputs hold their values.
- EDIT, r press: field+1, wrapping 5→0. l press: field−1, wrapping 0→5.
- EDIT, up/down press: the selected field steps +1/−1 with wrap-around. Ranges:
  - year: YEAR_MIN..YEAR_MAX
  - month: 1..12
  - day: 1..dim(month, year)
  - hour: 0..23
  - min: 0..59
  - sec: 0..59
- Auto-repeat: while up or down stays held (debounced high) and alone, one extra step occurs after REPEAT_DELAY_CYC cycles, then one every REPEAT_RATE_CYC cycles. The counter restarts on release or on a field change.
- dim (days in month): 31/30 per month. February is 29 when year[1:0]==0, else 28. This rule is valid for the range 2001–2099.
- When month or year changes, day is clamped in the same cycle to min(day, dim).
- Priority when events coincide in one cycle: mid > l/r > up/down.
  - l and r together: both ignored.
  - up and down held together: both ignored, and the repeat counter is cleared.
- rst asserted mid-edit: EDIT is abandoned immediately, with no commit.

## Timing
- Reset values: year_d=YEAR_MIN, month_d=1, day_d=1, hour_d=0, min_d=0, sec_d=0, field=0, editing=0, blink=0, commit=0. The debouncers clear to "released".
- Press latency: after a raw level becomes stable, the debounced level changes DEBOUNCE_CYC+2 cycles later. The resulting output/field update is registered one cycle after that (DEBOUNCE_CYC+3 total).
- Load on entry: outputs show the cur_* values sampled in the cycle of the press event, valid on the next edge. editing rises on the same edge.
- commit is high for exactly one cycle. It rises on the same edge that editing falls.
- All outputs are registered; there is no combinational input→output path.

## Structure
- Package time_set_pkg holds:
  - field index localparams F_YEAR..F_SEC;
  - the function days_in_month(month, year);
  - the per-field min/max constants.
- Sub-module btn_debounce: synchroniser plus stability counter, parameter DEBOUNCE_CYC, outputs level and press pulse. It is instantiated five times.
- Top level holds the FSM, the field register, the repeat timer, the blink timer and the value registers.

## Test plan
All scenarios use DEBOUNCE_CYC=4, REPEAT_DELAY_CYC=20, REPEAT_RATE_CYC=5, BLINK_CYC=8.
- Reset, then 3-cycle glitch on button_up: all outputs at reset values, no change.
- cur=2024-02-29 13:05:07, press mid: editing=1 and outputs equal cur after 7 cycles. Press up with field=0: year_d=2025, day_d clamps to 28.
- Field=5, sec=59, up: sec_d=0. Then r: field=0. Then l twice: field=4.
- Hold down on min=3 for 40 stable cycles: 1 press step, then repeats at +20 and every 5 cycles after. min_d sequence 2,1,0,59,58.
- Up and down held together: no change. Press mid: commit high exactly one cycle, editing=0, values retained.
- rst asserted during EDIT: next edge gives all reset values, commit stays 0.

Source files
------------

// File: rtl/time_set_pkg.sv
// Shared definitions for the time/date field editor.
//   - FSM state type
//   - field index constants (0=year .. 5=sec)
//   - per-field lower/upper limits (year limits are parameters of the top)
//   - days_in_month(): calendar length of a month, leap rule valid 2001..2099
package time_set_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EDIT = 1'b1
    } edit_state_e;

    localparam logic [2:0] F_YEAR  = 3'd0;
    localparam logic [2:0] F_MONTH = 3'd1;
    localparam logic [2:0] F_DAY   = 3'd2;
    localparam logic [2:0] F_HOUR  = 3'd3;
    localparam logic [2:0] F_MIN   = 3'd4;
    localparam logic [2:0] F_SEC   = 3'd5;

    localparam logic [3:0] MONTH_MIN = 4'd1;
    localparam logic [3:0] MONTH_MAX = 4'd12;
    localparam logic [4:0] DAY_MIN   = 5'd1;
    localparam logic [5:0] HOUR_MIN  = 6'd0;
    localparam logic [5:0] HOUR_MAX  = 6'd23;
    localparam logic [5:0] MIN_MIN   = 6'd0;
    localparam logic [5:0] MIN_MAX   = 6'd59;
    localparam logic [5:0] SEC_MIN   = 6'd0;
    localparam logic [5:0] SEC_MAX   = 6'd59;

    // Every year divisible by 4 is a leap year inside 2001..2099.
    function automatic logic [4:0] days_in_month(input logic [3:0] month,
                                                 input logic [14:0] year);
        logic [4:0] dim;
        logic       leap;
        leap = ((year % 15'd4) == 15'd0);
        case (month)
            4'd2:                    dim = leap ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11: dim = 5'd30;
            default:                 dim = 5'd31;
        endcase
        return dim;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser followed by a stability counter.
// Ports:
//   clk, rst  - clock, synchronous active-high reset (level clears to released)
//   button    - raw asynchronous button input
//   level     - debounced level, changes DEBOUNCE_CYC+2 cycles after raw settles
//   press     - one-cycle pulse, registered together with the 0->1 level change
module btn_debounce #(
    parameter int DEBOUNCE_CYC = 20000
) (
    input  logic clk,
    input  logic rst,
    input  logic button,
    output logic level,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic             sync_1_r;
    logic             sync_2_r;
    logic [CNT_W-1:0] cnt_r;

    // Synchronise the raw input and accept a new level once it held long enough.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_1_r <= 1'b0;
            sync_2_r <= 1'b0;
            cnt_r    <= '0;
            level    <= 1'b0;
            press    <= 1'b0;
        end else begin
            sync_1_r <= button;
            sync_2_r <= sync_1_r;
            press    <= 1'b0;
            if (sync_2_r == level) begin
                cnt_r <= '0;
            end else if (cnt_r == CNT_LAST) begin
                level <= sync_2_r;
                press <= sync_2_r;
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/time_set_editor.sv
// Debounced, auto-repeating year/month/day/hour/min/sec editor.
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   button_mid/l/r/up/down        - raw push-buttons (enter/commit, field select, step)
//   cur_year..cur_sec             - running time, loaded when editing starts
//   year_d..sec_d                 - edited values (registered)
//   field                         - selected field, 0=year .. 5=sec
//   editing                       - high while in the edit state
//   blink                         - toggles every BLINK_CYC cycles while editing
//   commit                        - one-cycle strobe when the edit is accepted
module time_set_editor
    import time_set_pkg::*;
#(
    parameter int DEBOUNCE_CYC     = 20000,
    parameter int REPEAT_DELAY_CYC = 500000,
    parameter int REPEAT_RATE_CYC  = 100000,
    parameter int BLINK_CYC        = 250000,
    parameter int YEAR_MIN         = 2001,
    parameter int YEAR_MAX         = 2099
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        button_mid,
    input  logic        button_l,
    input  logic        button_r,
    input  logic        button_up,
    input  logic        button_down,
    input  logic [14:0] cur_year,
    input  logic [3:0]  cur_month,
    input  logic [4:0]  cur_day,
    input  logic [5:0]  cur_hour,
    input  logic [5:0]  cur_min,
    input  logic [5:0]  cur_sec,
    output logic [14:0] year_d,
    output logic [3:0]  month_d,
    output logic [4:0]  day_d,
    output logic [5:0]  hour_d,
    output logic [5:0]  min_d,
    output logic [5:0]  sec_d,
    output logic [2:0]  field,
    output logic        editing,
    output logic        blink,
    output logic        commit
);

    localparam logic [14:0] YEAR_LO    = 15'(YEAR_MIN);
    localparam logic [14:0] YEAR_HI    = 15'(YEAR_MAX);
    localparam logic [31:0] DELAY_LAST = 32'(REPEAT_DELAY_CYC - 1);
    localparam logic [31:0] RATE_LAST  = 32'(REPEAT_RATE_CYC - 1);
    localparam logic [31:0] BLINK_LAST = 32'(BLINK_CYC - 1);

    edit_state_e state_r;
    logic [31:0] rpt_cnt_r;
    logic        rpt_phase_r;     // 0: waiting for the initial delay, 1: repeating
    logic [31:0] blink_cnt_r;

    logic mid_lvl_s, l_lvl_s, r_lvl_s, up_lvl_s, down_lvl_s;
    logic mid_press_s, l_press_s, r_press_s, up_press_s, down_press_s;
    logic unused_lvl_s;

    logic        up_only_s, down_only_s, held_alone_s;
    logic        press_step_s, rpt_fire_s, step_s;
    logic [2:0]  field_next_s;
    logic [4:0]  dim_cur_s, dim_nxt_s, day_step_s;
    logic [14:0] nxt_year_s;
    logic [3:0]  nxt_month_s;
    logic [4:0]  nxt_day_s;
    logic [5:0]  nxt_hour_s, nxt_min_s, nxt_sec_s;

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_mid (
        .clk(clk), .rst(rst), .button(button_mid), .level(mid_lvl_s), .press(mid_press_s));
    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_l (
        .clk(clk), .rst(rst), .button(button_l), .level(l_lvl_s), .press(l_press_s));
    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_r (
        .clk(clk), .rst(rst), .button(button_r), .level(r_lvl_s), .press(r_press_s));
    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_up (
        .clk(clk), .rst(rst), .button(button_up), .level(up_lvl_s), .press(up_press_s));
    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_down (
        .clk(clk), .rst(rst), .button(button_down), .level(down_lvl_s), .press(down_press_s));

    // Only the press pulses matter for mid/l/r.
    assign unused_lvl_s = ^{mid_lvl_s, l_lvl_s, r_lvl_s};

    // Step requests: a fresh press or a due repeat, only while exactly one of up/down is held.
    always_comb begin
        up_only_s    = up_lvl_s & ~down_lvl_s;
        down_only_s  = down_lvl_s & ~up_lvl_s;
        held_alone_s = up_only_s | down_only_s;
        press_step_s = (up_press_s & up_only_s) | (down_press_s & down_only_s);
        rpt_fire_s   = held_alone_s &
                       (rpt_cnt_r == (rpt_phase_r ? RATE_LAST : DELAY_LAST));
        step_s       = press_step_s | rpt_fire_s;
        if (r_press_s) begin
            field_next_s = (field == F_SEC) ? F_YEAR : field + 3'd1;
        end else begin
            field_next_s = (field == F_YEAR) ? F_SEC : field - 3'd1;
        end
    end

    // Next value of the selected field after one step in the held direction, with wrap.
    always_comb begin
        nxt_year_s  = year_d;
        nxt_month_s = month_d;
        nxt_day_s   = day_d;
        nxt_hour_s  = hour_d;
        nxt_min_s   = min_d;
        nxt_sec_s   = sec_d;
        dim_cur_s   = days_in_month(month_d, year_d);
        case (field)
            F_YEAR: begin
                if (up_only_s) nxt_year_s = (year_d >= YEAR_HI) ? YEAR_LO : year_d + 15'd1;
                else           nxt_year_s = (year_d <= YEAR_LO) ? YEAR_HI : year_d - 15'd1;
            end
            F_MONTH: begin
                if (up_only_s) nxt_month_s = (month_d >= MONTH_MAX) ? MONTH_MIN : month_d + 4'd1;
                else           nxt_month_s = (month_d <= MONTH_MIN) ? MONTH_MAX : month_d - 4'd1;
            end
            F_DAY: begin
                if (up_only_s) nxt_day_s = (day_d >= dim_cur_s) ? DAY_MIN : day_d + 5'd1;
                else           nxt_day_s = (day_d <= DAY_MIN) ? dim_cur_s : day_d - 5'd1;
            end
            F_HOUR: begin
                if (up_only_s) nxt_hour_s = (hour_d >= HOUR_MAX) ? HOUR_MIN : hour_d + 6'd1;
                else           nxt_hour_s = (hour_d <= HOUR_MIN) ? HOUR_MAX : hour_d - 6'd1;
            end
            F_MIN: begin
                if (up_only_s) nxt_min_s = (min_d >= MIN_MAX) ? MIN_MIN : min_d + 6'd1;
                else           nxt_min_s = (min_d <= MIN_MIN) ? MIN_MAX : min_d - 6'd1;
            end
            F_SEC: begin
                if (up_only_s) nxt_sec_s = (sec_d >= SEC_MAX) ? SEC_MIN : sec_d + 6'd1;
                else           nxt_sec_s = (sec_d <= SEC_MIN) ? SEC_MAX : sec_d - 6'd1;
            end
            default: begin
                nxt_year_s = year_d;
            end
        endcase
        // A month/year change can shorten the month; pull the day back in the same cycle.
        dim_nxt_s  = days_in_month(nxt_month_s, nxt_year_s);
        day_step_s = ((field == F_YEAR || field == F_MONTH) && (nxt_day_s > dim_nxt_s))
                     ? dim_nxt_s : nxt_day_s;
    end

    // Editor FSM with registered value, field, blink, repeat and commit state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            year_d      <= YEAR_LO;
            month_d     <= MONTH_MIN;
            day_d       <= DAY_MIN;
            hour_d      <= HOUR_MIN;
            min_d       <= MIN_MIN;
            sec_d       <= SEC_MIN;
            field       <= F_YEAR;
            editing     <= 1'b0;
            blink       <= 1'b0;
            commit      <= 1'b0;
            rpt_cnt_r   <= 32'd0;
            rpt_phase_r <= 1'b0;
            blink_cnt_r <= 32'd0;
        end else begin
            commit <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    blink       <= 1'b0;
                    blink_cnt_r <= 32'd0;
                    rpt_cnt_r   <= 32'd0;
                    rpt_phase_r <= 1'b0;
                    if (mid_press_s) begin
                        year_d  <= cur_year;
                        month_d <= cur_month;
                        day_d   <= cur_day;
                        hour_d  <= cur_hour;
                        min_d   <= cur_min;
                        sec_d   <= cur_sec;
                        field   <= F_YEAR;
                        editing <= 1'b1;
                        state_r <= ST_EDIT;
                    end
                end
                ST_EDIT: begin
                    if (blink_cnt_r == BLINK_LAST) begin
                        blink       <= ~blink;
                        blink_cnt_r <= 32'd0;
                    end else begin
                        blink_cnt_r <= blink_cnt_r + 32'd1;
                    end

                    if (mid_press_s) begin
                        commit      <= 1'b1;
                        editing     <= 1'b0;
                        blink       <= 1'b0;
                        blink_cnt_r <= 32'd0;
                        rpt_cnt_r   <= 32'd0;
                        rpt_phase_r <= 1'b0;
                        state_r     <= ST_IDLE;
                    end else if (l_press_s | r_press_s) begin
                        // l and r in the same cycle cancel each other.
                        if (l_press_s ^ r_press_s) begin
                            field <= field_next_s;
                        end
                        rpt_cnt_r   <= 32'd0;
                        rpt_phase_r <= 1'b0;
                    end else begin
                        if (step_s) begin
                            year_d  <= nxt_year_s;
                            month_d <= nxt_month_s;
                            day_d   <= day_step_s;
                            hour_d  <= nxt_hour_s;
                            min_d   <= nxt_min_s;
                            sec_d   <= nxt_sec_s;
                        end
                        if (!held_alone_s) begin
                            rpt_cnt_r   <= 32'd0;
                            rpt_phase_r <= 1'b0;
                        end else if (step_s) begin
                            rpt_cnt_r   <= 32'd0;
                            rpt_phase_r <= ~press_step_s;
                        end else begin
                            rpt_cnt_r <= rpt_cnt_r + 32'd1;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    editing <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_time_set_editor.sv
module tb_time_set_editor;

    localparam int B_MID  = 0;
    localparam int B_L    = 1;
    localparam int B_R    = 2;
    localparam int B_UP   = 3;
    localparam int B_DOWN = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        button_mid = 1'b0, button_l = 1'b0, button_r = 1'b0;
    logic        button_up = 1'b0, button_down = 1'b0;
    logic [14:0] cur_year = 15'd2024;
    logic [3:0]  cur_month = 4'd2;
    logic [4:0]  cur_day = 5'd29;
    logic [5:0]  cur_hour = 6'd13, cur_min = 6'd5, cur_sec = 6'd7;
    logic [14:0] year_d;
    logic [3:0]  month_d;
    logic [4:0]  day_d;
    logic [5:0]  hour_d, min_d, sec_d;
    logic [2:0]  field;
    logic        editing, blink, commit;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    time_set_editor #(
        .DEBOUNCE_CYC(4), .REPEAT_DELAY_CYC(20), .REPEAT_RATE_CYC(5),
        .BLINK_CYC(8), .YEAR_MIN(2001), .YEAR_MAX(2099)
    ) dut (
        .clk(clk), .rst(rst),
        .button_mid(button_mid), .button_l(button_l), .button_r(button_r),
        .button_up(button_up), .button_down(button_down),
        .cur_year(cur_year), .cur_month(cur_month), .cur_day(cur_day),
        .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
        .year_d(year_d), .month_d(month_d), .day_d(day_d),
        .hour_d(hour_d), .min_d(min_d), .sec_d(sec_d),
        .field(field), .editing(editing), .blink(blink), .commit(commit)
    );

    task automatic drive(input int idx, input logic v);
        case (idx)
            B_MID:   button_mid  = v;
            B_L:     button_l    = v;
            B_R:     button_r    = v;
            B_UP:    button_up   = v;
            B_DOWN:  button_down = v;
            default: button_mid  = button_mid;
        endcase
    endtask

    // Press for 10 cycles, release for 10: one press event, levels settled afterwards.
    task automatic tap(input int idx);
        drive(idx, 1'b1);
        repeat (10) @(negedge clk);
        drive(idx, 1'b0);
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({year_d, month_d, day_d, hour_d, min_d, sec_d} !== {15'd2001, 4'd1, 5'd1, 6'd0, 6'd0, 6'd0}) begin
            errors++;
            $display("FAIL reset_values: got %0d-%0d-%0d %0d:%0d:%0d expected 2001-1-1 0:0:0",
                     year_d, month_d, day_d, hour_d, min_d, sec_d);
        end
        checks++;
        if ({field, editing, blink, commit} !== {3'd0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_flags: got field=%0d editing=%0b blink=%0b commit=%0b expected 0 0 0 0",
                     field, editing, blink, commit);
        end
        // 3-cycle glitch is shorter than the debounce window
        drive(B_UP, 1'b1);
        repeat (3) @(negedge clk);
        drive(B_UP, 1'b0);
        repeat (12) @(negedge clk);
        checks++;
        if ({year_d, month_d, day_d, field, editing, commit} !== {15'd2001, 4'd1, 5'd1, 3'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL glitch_ignored: got year=%0d month=%0d day=%0d field=%0d editing=%0b commit=%0b expected 2001 1 1 0 0 0",
                     year_d, month_d, day_d, field, editing, commit);
        end
    endtask

    task automatic test_entry_and_clamp;
        drive(B_MID, 1'b1);
        repeat (6) @(negedge clk);
        checks++;
        if (editing !== 1'b0) begin
            errors++;
            $display("FAIL entry_latency_early: editing got %0b expected 0", editing);
        end
        @(negedge clk);
        checks++;
        if ({editing, field, blink} !== {1'b1, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL entry_flags: got editing=%0b field=%0d blink=%0b expected 1 0 0", editing, field, blink);
        end
        checks++;
        if ({year_d, month_d, day_d, hour_d, min_d, sec_d} !== {15'd2024, 4'd2, 5'd29, 6'd13, 6'd5, 6'd7}) begin
            errors++;
            $display("FAIL entry_load: got %0d-%0d-%0d %0d:%0d:%0d expected 2024-2-29 13:5:7",
                     year_d, month_d, day_d, hour_d, min_d, sec_d);
        end
        repeat (7) @(negedge clk);
        checks++;
        if (blink !== 1'b0) begin
            errors++;
            $display("FAIL blink_before_toggle: got %0b expected 0", blink);
        end
        @(negedge clk);
        checks++;
        if (blink !== 1'b1) begin
            errors++;
            $display("FAIL blink_toggle: got %0b expected 1", blink);
        end
        drive(B_MID, 1'b0);
        repeat (10) @(negedge clk);
        tap(B_UP);
        checks++;
        if ({year_d, month_d, day_d} !== {15'd2025, 4'd2, 5'd28}) begin
            errors++;
            $display("FAIL year_up_day_clamp: got %0d-%0d-%0d expected 2025-2-28", year_d, month_d, day_d);
        end
    endtask

    task automatic test_field_wrap;
        tap(B_L);
        checks++;
        if (field !== 3'd5) begin
            errors++;
            $display("FAIL field_l_wrap: got %0d expected 5", field);
        end
        for (int i = 0; i < 8; i++) tap(B_DOWN);
        checks++;
        if (sec_d !== 6'd59) begin
            errors++;
            $display("FAIL sec_down_wrap: got %0d expected 59", sec_d);
        end
        tap(B_UP);
        checks++;
        if (sec_d !== 6'd0) begin
            errors++;
            $display("FAIL sec_up_wrap: got %0d expected 0", sec_d);
        end
        tap(B_R);
        checks++;
        if (field !== 3'd0) begin
            errors++;
            $display("FAIL field_r_wrap: got %0d expected 0", field);
        end
        tap(B_L);
        tap(B_L);
        checks++;
        if (field !== 3'd4) begin
            errors++;
            $display("FAIL field_l_twice: got %0d expected 4", field);
        end
        tap(B_DOWN);
        tap(B_DOWN);
        checks++;
        if (min_d !== 6'd3) begin
            errors++;
            $display("FAIL min_down_to_3: got %0d expected 3", min_d);
        end
    endtask

    task automatic test_auto_repeat;
        logic [5:0] exp_min;
        drive(B_DOWN, 1'b1);
        for (int c = 1; c <= 55; c++) begin
            @(negedge clk);
            if (c < 7)       exp_min = 6'd3;
            else if (c < 27) exp_min = 6'd2;
            else if (c < 32) exp_min = 6'd1;
            else if (c < 37) exp_min = 6'd0;
            else if (c < 42) exp_min = 6'd59;
            else             exp_min = 6'd58;
            checks++;
            if (min_d !== exp_min) begin
                errors++;
                $display("FAIL repeat_seq cycle %0d: got %0d expected %0d", c, min_d, exp_min);
            end
            if (c == 40) drive(B_DOWN, 1'b0);
        end
    endtask

    task automatic test_up_down_together;
        drive(B_UP, 1'b1);
        drive(B_DOWN, 1'b1);
        repeat (40) @(negedge clk);
        checks++;
        if (min_d !== 6'd58) begin
            errors++;
            $display("FAIL up_down_held: got %0d expected 58", min_d);
        end
        drive(B_UP, 1'b0);
        drive(B_DOWN, 1'b0);
        repeat (10) @(negedge clk);
    endtask

    task automatic test_commit;
        drive(B_MID, 1'b1);
        repeat (6) @(negedge clk);
        checks++;
        if ({commit, editing} !== {1'b0, 1'b1}) begin
            errors++;
            $display("FAIL commit_early: got commit=%0b editing=%0b expected 0 1", commit, editing);
        end
        @(negedge clk);
        checks++;
        if ({commit, editing} !== {1'b1, 1'b0}) begin
            errors++;
            $display("FAIL commit_pulse: got commit=%0b editing=%0b expected 1 0", commit, editing);
        end
        @(negedge clk);
        checks++;
        if (commit !== 1'b0) begin
            errors++;
            $display("FAIL commit_one_cycle: got %0b expected 0", commit);
        end
        checks++;
        if ({year_d, month_d, day_d, hour_d, min_d, sec_d} !== {15'd2025, 4'd2, 5'd28, 6'd13, 6'd58, 6'd0}) begin
            errors++;
            $display("FAIL commit_retain: got %0d-%0d-%0d %0d:%0d:%0d expected 2025-2-28 13:58:0",
                     year_d, month_d, day_d, hour_d, min_d, sec_d);
        end
        drive(B_MID, 1'b0);
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset_mid_edit;
        tap(B_MID);
        checks++;
        if ({editing, year_d} !== {1'b1, 15'd2024}) begin
            errors++;
            $display("FAIL reenter_edit: got editing=%0b year=%0d expected 1 2024", editing, year_d);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({year_d, month_d, day_d, hour_d, min_d, sec_d} !== {15'd2001, 4'd1, 5'd1, 6'd0, 6'd0, 6'd0}) begin
            errors++;
            $display("FAIL rst_mid_edit_values: got %0d-%0d-%0d %0d:%0d:%0d expected 2001-1-1 0:0:0",
                     year_d, month_d, day_d, hour_d, min_d, sec_d);
        end
        checks++;
        if ({field, editing, blink, commit} !== {3'd0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL rst_mid_edit_flags: got field=%0d editing=%0b blink=%0b commit=%0b expected 0 0 0 0",
                     field, editing, blink, commit);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({commit, editing} !== {1'b0, 1'b0}) begin
            errors++;
            $display("FAIL rst_no_commit: got commit=%0b editing=%0b expected 0 0", commit, editing);
        end
    endtask

    initial begin
        test_reset();
        test_entry_and_clamp();
        test_field_wrap();
        test_auto_repeat();
        test_up_down_together();
        test_commit();
        test_reset_mid_edit();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
